regfile_write_port: RTL and testbench
=====================================

# regfile_write_port

Write side of the 32×32 register file. Accepts single-register writes over a valid/ready handshake, decodes the 5-bit address to a one-hot enable, and holds the storage array. All registers are exposed as a flat bus that feeds the 32:1 read multiplexer. A runtime clear sequencer zeroes the array one register per cycle.

## Interface
Parameters:
- `WIDTH`, 32, register width in bits
- `DEPTH`, 32, number of registers; must equal 2**`ADDR_W`
- `ADDR_W`, 5, address width
- `ZERO_REG`, 1, when 1 register 0 is hardwired to zero

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `wr_valid` input 1: write request present.
- `wr_ready` output 1: the port can accept a write this cycle.
- `wr_addr` input `ADDR_W`: target register index.
- `wr_data` input `WIDTH`: write data.
- `clr_req` input 1: single-cycle or level request to start the clear sequence.
- `clr_busy` output 1: the clear sequence is in progress.
- `regs_flat` output `WIDTH*DEPTH`: register k on bits [`WIDTH`*k+`WIDTH`-1 : `WIDTH`*k].

## Operation
- State machine with two states:
  - `IDLE` → `CLEAR` when `clr_req`=1.
  - `CLEAR` → `IDLE` after the cycle in which the counter equals `DEPTH`-1.
- `wr_ready` is combinational: `wr_ready` = (state==`IDLE`) && !`clr_req`.
- Write acceptance:
  - A write is accepted on a rising edge where `wr_valid` && `wr_ready`.
  - The one-hot decode of `wr_addr` enables exactly one register, which loads `wr_data`.
- Writes to address 0 when `ZERO_REG`=1 are accepted (handshake completes) but discarded. Register 0 reads 0 at all times.
- Clear sequence:
  - The clear counter is `ADDR_W` bits and is reset to 0 on entry to `CLEAR`.
  - Each `CLEAR` cycle zeroes register[counter] and increments the counter.
  - The sequence takes exactly `DEPTH` cycles.
- `clr_req` asserted while in `CLEAR` is ignored. The sequence does not restart or extend.
- `clr_req` and `wr_valid` in the same `IDLE` cycle: clear wins. The write is not accepted, and the requester must hold it until `wr_ready` returns.
- `wr_valid` held during `CLEAR` stalls. `wr_addr` and `wr_data` must stay stable until accepted.
- No combinational path from `wr_data` to `regs_flat`.

## Timing
- Reset values:
  - All registers are 0, so `regs_flat`=0.
  - State is `IDLE` and the counter is 0.
  - `clr_busy`=0.
  - `wr_ready`=1 unless `clr_req` is high.
- Reset asserted mid-clear or mid-write aborts immediately. All state returns to reset values asynchronously.
- Write latency is 1: data accepted at edge N is visible on `regs_flat` after edge N.
- Clear timing:
  - `clr_busy` is registered. It rises the cycle after `clr_req` is sampled in `IDLE`.
  - `clr_busy` stays high for `DEPTH` cycles, then falls, and `wr_ready` returns the same cycle.
- Register k is zero from the edge ending `CLEAR` cycle k onward. Registers not yet reached keep their old values.
- Throughput: one write per cycle in `IDLE` with `wr_valid` held high.

## Structure
- Package `regfile_pkg` holds:
  - constants `WIDTH`, `DEPTH`, `ADDR_W`
  - the state enum `{IDLE, CLEAR}`
- The read multiplexer imports the same package.
- Sub-module `addr_decoder`:
  - input `ADDR_W`-bit address plus enable
  - output `DEPTH`-bit one-hot
  - shared by the write path and the clear path, with the address muxed by state
- Top-level contents: storage array, FSM, clear counter.

## Test plan
- Reset, then write 0xDEADBEEF to addr 5 → after one edge, reg 5 = 0xDEADBEEF and every other register = 0.
- Back-to-back writes to addr 1, 2 and 31 on consecutive cycles with 0x1, 0x2 and 0xFFFFFFFF → all three visible, `wr_ready` stays 1 throughout.
- Write 0x12345678 to addr 0 with `ZERO_REG`=1 → handshake completes, reg 0 stays 0.
- Fill all registers with 0xA5A5A5A5, pulse `clr_req` → `clr_busy` high for exactly 32 cycles. Then:
  - mid-sequence (after 10 busy cycles), regs 1–9 = 0 and regs 10–31 still hold 0xA5A5A5A5
  - at the end, all registers = 0
- `clr_req` and `wr_valid` (addr 3, 0x77) in the same cycle → write stalls with `wr_ready`=0 for 33 cycles, then lands, and reg 3 = 0x77 after the clear completes.
- Assert `rst_n`=0 at `CLEAR` cycle 15 → `clr_busy`=0, `regs_flat`=0 and `wr_ready`=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register file slice.
package regfile_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_write_port_addr_decoder.sv
// Address to one-hot register enable decoder, shared by the write and clear paths.
module addr_decoder #(
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned DEPTH  = regfile_pkg::DEPTH
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [DEPTH-1:0]  onehot
);

  // One bit set for the addressed register when enabled, none otherwise.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (en && (addr == ADDR_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_port.sv
// Register file write side: handshaked single-register writes, storage array,
// flat read-out bus and a one-register-per-cycle clear sequencer.
module regfile_write_port #(
  parameter int unsigned WIDTH    = regfile_pkg::WIDTH,
  parameter int unsigned DEPTH    = regfile_pkg::DEPTH,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic [WIDTH*DEPTH-1:0] regs_flat
);

  import regfile_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];

  logic              clearing;
  logic              wr_fire;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_en;
  logic [DEPTH-1:0]  sel;

  assign clearing = (state_q == CLEAR);
  assign wr_ready = (state_q == IDLE) && !clr_req;
  assign wr_fire  = wr_valid && wr_ready;
  assign clr_busy = busy_q;

  // One decoder serves both paths: the clear counter owns it while clearing.
  assign dec_addr = clearing ? cnt_q : wr_addr;
  assign dec_en   = clearing ? 1'b1  : wr_fire;

  addr_decoder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_decoder (
    .addr   (dec_addr),
    .en     (dec_en),
    .onehot (sel)
  );

  // Next-state, clear counter and busy flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Busy is registered from the next state so it tracks CLEAR without a
    // combinational path from clr_req.
    busy_d = (state_d == CLEAR);
  end

  // Storage next values: selected register loads write data or zero.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      regs_d[k] = regs_q[k];
      if (sel[k]) begin
        regs_d[k] = clearing ? '0 : wr_data;
      end
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_flat[WIDTH*g +: WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port: vector table, directed corner
// sequences and randomized traffic against an array-based reference model.
module tb_regfile_write_port;

  localparam int W = 32;
  localparam int D = 32;
  localparam int A = 5;

  logic           clk;
  logic           rst_n;
  logic           wr_valid;
  logic           wr_ready;
  logic [A-1:0]   wr_addr;
  logic [W-1:0]   wr_data;
  logic           clr_req;
  logic           clr_busy;
  logic [W*D-1:0] regs_flat;

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents plus remaining clear cycles.
  logic [W-1:0] m_reg [D];
  int           m_left;
  int           m_idx;

  regfile_write_port #(
    .WIDTH    (W),
    .DEPTH    (D),
    .ADDR_W   (A),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .regs_flat (regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [A-1:0] addr;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [W-1:0] dut_reg(input int k);
    return regs_flat[k*W +: W];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < D; k++) m_reg[k] = '0;
    m_left = 0;
    m_idx  = 0;
  endtask

  // Effect of one rising edge, from the inputs present at that edge.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (m_left > 0) begin
      m_reg[m_idx] = '0;
      m_idx++;
      m_left--;
    end else if (clr_req) begin
      m_left = D;
      m_idx  = 0;
    end else if (wr_valid && (wr_addr != 0)) begin
      m_reg[wr_addr] = wr_data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    int bad;
    bad = -1;
    checks++;
    for (int k = D - 1; k >= 0; k--) begin
      if (dut_reg(k) !== m_reg[k]) bad = k;
    end
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: reg%0d got %h expected %h", name, bad, dut_reg(bad), m_reg[bad]);
    end
  endtask

  task automatic check_all(input string name);
    check({name, "/busy"}, 32'(clr_busy), 32'(m_left > 0));
    check({name, "/ready"}, 32'(wr_ready), 32'((m_left == 0) && !clr_req));
    check_regs({name, "/regs"});
  endtask

  initial begin
    int busy_cnt;
    int stall;

    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
    model_reset();

    tbl[0] = '{5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1] = '{5'd1,  32'h00000001, 32'h00000001};
    tbl[2] = '{5'd2,  32'h00000002, 32'h00000002};
    tbl[3] = '{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[4] = '{5'd0,  32'h12345678, 32'h00000000};
    tbl[5] = '{5'd5,  32'h00000000, 32'h00000000};
    tbl[6] = '{5'd30, 32'h5A5A0F0F, 32'h5A5A0F0F};

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_flat_or", 32'(|regs_flat), 32'd0);
    check("reset_busy", 32'(clr_busy), 32'd0);
    check("reset_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table writes; ready must be high before every edge
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      wr_addr  = tbl[i].addr;
      wr_data  = tbl[i].data;
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(wr_ready), 32'd1);
      step();
      check($sformatf("tbl%0d_reg", i), dut_reg(int'(tbl[i].addr)), tbl[i].exp);
      check_regs($sformatf("tbl%0d_all", i));
    end
    wr_valid = 1'b0;

    // Fill with A5 pattern, then clear
    for (int k = 0; k < D; k++) begin
      wr_valid = 1'b1;
      wr_addr  = A'(k);
      wr_data  = 32'hA5A5A5A5;
      step();
    end
    wr_valid = 1'b0;
    check("fill_reg17", dut_reg(17), 32'hA5A5A5A5);
    check("fill_reg0", dut_reg(0), 32'h0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    #1;
    check("clr_busy_rise", 32'(clr_busy), 32'd1);
    check("clr_ready_low", 32'(wr_ready), 32'd0);
    busy_cnt = 1;
    while (clr_busy === 1'b1 && busy_cnt < 100) begin
      step();
      if (busy_cnt == 10) begin
        check("clr_mid_reg9", dut_reg(9), 32'h0);
        check("clr_mid_reg1", dut_reg(1), 32'h0);
        check("clr_mid_reg10", dut_reg(10), 32'hA5A5A5A5);
        check("clr_mid_reg31", dut_reg(31), 32'hA5A5A5A5);
        check_all("clr_mid");
      end
      if (clr_busy === 1'b1) busy_cnt++;
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    check("clr_end_flat_or", 32'(|regs_flat), 32'd0);
    check_all("clr_end");

    // Clear and write requested together: write waits out the whole clear
    wr_valid = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'h00000077;
    clr_req  = 1'b1;
    #1;
    stall = 0;
    while (wr_ready !== 1'b1 && stall < 200) begin
      check_regs($sformatf("stall%0d", stall));
      step();
      stall++;
      clr_req = 1'b0;
      #1;
    end
    check("stall_cycles", 32'(stall), 32'd33);
    check("stall_reg3_before", dut_reg(3), 32'h0);
    step();
    wr_valid = 1'b0;
    check("stall_reg3_after", dut_reg(3), 32'h00000077);
    check_all("stall_done");

    // Asynchronous reset during clear cycle 15
    wr_valid = 1'b1;
    wr_addr  = 5'd20;
    wr_data  = 32'hCAFEF00D;
    step();
    wr_addr  = 5'd31;
    wr_data  = 32'h13579BDF;
    step();
    wr_valid = 1'b0;
    clr_req  = 1'b1;
    step();
    clr_req  = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("pre_rst_busy", 32'(clr_busy), 32'd1);
    check("pre_rst_reg20", dut_reg(20), 32'hCAFEF00D);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_busy", 32'(clr_busy), 32'd0);
    check("arst_ready", 32'(wr_ready), 32'd1);
    check("arst_flat_or", 32'(|regs_flat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("arst_release");

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = A'($urandom);
      wr_data  = $urandom;
      clr_req  = ($urandom_range(0, 39) == 0);
      #1;
      check_all($sformatf("rnd%0d_pre", c));
      step();
    end
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    #1;
    check_all("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
